bg_mem_port_arbiter: RTL and testbench
======================================

Name: bg_mem_port_arbiter

Overview:
Shares the 16-bit background-memory s2 port between two fabric requesters: requester 0 is the LT24 pixel fetch engine, requester 1 is the PIC32 SPI copy engine.
- Grants at most one access per cycle, using round-robin with an optional bounded burst lock.
- Registers the command onto the memory port.
- Routes each read return to the requester that issued it, using a latency-matched owner-tag pipeline.
- Sits between the requesters and the SOPC background_mem s2 conduit.

Parameters:
ADDR_W, 13, memory word-address width
DATA_W, 16, data width; byte-enable width is DATA_W/8
READ_LATENCY, 1, cycles from a registered read command at the port to valid mem_readdata (legal 1..3)
MAX_BURST, 16, maximum consecutive grants a locked requester may hold while the other requester is waiting (legal 2..255)

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  synchronous active-high reset
rq0_req / rq1_req  in  1  access request
rq0_lock / rq1_lock  in  1  ask to keep the grant on the following cycle
rq0_write / rq1_write  in  1  1 = write, 0 = read
rq0_addr / rq1_addr  in  ADDR_W  word address
rq0_wdata / rq1_wdata  in  DATA_W  write data
rq0_be / rq1_be  in  DATA_W/8  byte enables
rq0_gnt / rq1_gnt  out  1  request accepted this cycle (combinational)
rq0_rvalid / rq1_rvalid  out  1  read data valid
rq0_rdata / rq1_rdata  out  DATA_W  read data (both driven from mem_readdata)
mem_address  out  ADDR_W  to s2 address
mem_chipselect  out  1  to s2 chipselect
mem_clken  out  1  to s2 clken
mem_write  out  1  to s2 write
mem_writedata  out  DATA_W  to s2 writedata
mem_byteenable  out  DATA_W/8  to s2 byteenable
mem_readdata  in  DATA_W  from s2 readdata

Behaviour:
- Handshake: a request is transferred in cycle N when rqX_req and rqX_gnt are both 1.
  - The requester holds its req and payload stable until it sees gnt.
  - At most one gnt is high in any cycle.
  - gnt is never asserted without req.
- Arbiter states:
  - IDLE: no owner.
  - OWN0 / OWN1: the last granted requester holds a lock.
- Round-robin pointer `last`:
  - Reset value is 1, so requester 0 wins the first contention.
  - When only one requester asserts req, it is granted.
  - When both assert req in IDLE, the grant goes to !last.
- Burst lock:
  - A granted transfer with rqX_lock=1 moves the arbiter to OWNX and increments burst_cnt.
  - In OWNX, requester X is granted whenever it asserts req, even if the other requester is waiting.
  - OWNX returns to IDLE when any of these occur:
    - X's transfer has lock=0;
    - X deasserts req;
    - burst_cnt reaches MAX_BURST while the other requester's req=1.
  - In the forced-release case, the next cycle grants the other requester.
  - burst_cnt clears on every exit from OWNX.
  - burst_cnt saturates at MAX_BURST when nobody else is requesting; the lock then continues.
- Command register: on a transfer in cycle N, cycle N+1 carries:
  - mem_chipselect=1 and mem_write = rqX_write;
  - address, writedata and byteenable copied from requester X.
  - With no transfer, mem_chipselect=0 and mem_write=0; the other mem outputs hold their last values.
- mem_clken is 1 at all times except during reset.
- Read return:
  - A read transferred in cycle N produces rqX_rvalid=1 for exactly one cycle, in cycle N+1+READ_LATENCY.
  - rqX_rdata equals mem_readdata in that cycle.
  - Writes never produce rvalid.
  - Owner tags travel through a (READ_LATENCY+1)-stage shift register. Back-to-back reads from alternating requesters return in issue order, one per cycle, with no bubbles.
- Throughput: one transfer per cycle, sustained.
- Reset (synchronous):
  - all mem_* outputs go to 0, including mem_clken;
  - rqX_gnt=0 while reset_reset=1;
  - rqX_rvalid=0;
  - the tag pipeline clears, and reads in flight when reset asserts are discarded with no rvalid;
  - state goes to IDLE, last=1, burst_cnt=0.
- Simultaneous events:
  - If lock release and the other requester's new req land in the same cycle, the other requester is granted on the next cycle.
  - If both requesters assert req in the first cycle after reset, requester 0 is granted.

Test Plan:
- Reset, then rq0 reads 0x0040 in cycle 0 → mem_chipselect=1 and mem_address=0x0040 in cycle 1; rq0_rvalid=1 in cycle 2 with rdata = model[0x0040]; rq1_rvalid stays 0.
- Both requesters stream reads continuously for 8 cycles → grants alternate 0,1,0,1…; rvalid alternates in the same order, 2 cycles behind each grant; no cycle has both gnt high.
- rq1 holds lock with a continuous req while rq0 requests, MAX_BURST=4 → rq1 gets exactly 4 consecutive grants, then rq0 is granted on the next cycle.
- rq0 writes 0xBEEF to 0x1FFF with be=2'b10, then reads it back → mem_write=1 with be=2'b10 on the write; the read returns 0xBE in the upper byte, lower byte unchanged.
- Assert reset_reset for 1 cycle while 2 reads are in flight → no rvalid fires afterwards; all mem_* outputs are 0 during the reset cycle; the first post-reset contention grants rq0.
- Sweep READ_LATENCY=1,2,3 with random traffic → every read's rvalid arrives at grant+1+READ_LATENCY; scoreboard shows zero mismatches.

Source files
------------

// File: rtl/bg_mem_port_arbiter.sv
// Two-requester arbiter for the 16-bit background-memory s2 port.
// Requester 0 is the LT24 pixel fetch engine and requester 1 is the PIC32 SPI copy engine.
// The arbiter grants one transfer per cycle. It uses round-robin with an optional
// bounded burst lock, registers the command onto the memory port, and routes each
// read return to its issuer through an owner-tag pipeline matched to the read latency.
//
// Ports:
//   clk_clk, reset_reset        clock, synchronous active-high reset
//   rqN_req/lock/write          request, keep-grant hint, 1=write / 0=read
//   rqN_addr/wdata/be           word address, write data, byte enables
//   rqN_gnt                     transfer accepted this cycle (combinational)
//   rqN_rvalid/rdata            read return for requester N
//   mem_*                       s2 conduit (address, chipselect, clken, write,
//                               writedata, byteenable, readdata)
module bg_mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_BURST    = 16
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                rq0_req,
  input  logic                rq0_lock,
  input  logic                rq0_write,
  input  logic [ADDR_W-1:0]   rq0_addr,
  input  logic [DATA_W-1:0]   rq0_wdata,
  input  logic [DATA_W/8-1:0] rq0_be,
  output logic                rq0_gnt,
  output logic                rq0_rvalid,
  output logic [DATA_W-1:0]   rq0_rdata,
  input  logic                rq1_req,
  input  logic                rq1_lock,
  input  logic                rq1_write,
  input  logic [ADDR_W-1:0]   rq1_addr,
  input  logic [DATA_W-1:0]   rq1_wdata,
  input  logic [DATA_W/8-1:0] rq1_be,
  output logic                rq1_gnt,
  output logic                rq1_rvalid,
  output logic [DATA_W-1:0]   rq1_rdata,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_clken,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int unsigned BeW       = DATA_W / 8;
  localparam int unsigned CntW      = $clog2(MAX_BURST + 1);
  localparam int unsigned TagStages = READ_LATENCY + 1;

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e             state_q;
  logic               last_q;
  logic [CntW-1:0]    burst_cnt_q;

  logic               burst_full;
  logic               hold0, hold1;
  logic               gnt0, gnt1;
  logic               lock_sel;
  state_e             own_st;

  logic               cs_q, we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [BeW-1:0]     be_q;

  logic [TagStages-1:0] tag_v_q, tag_o_q;
  logic                 rd_xfer;

  assign burst_full = (burst_cnt_q == CntW'(MAX_BURST));

  always_comb begin
    // The lock owner keeps the port unless it has used its full burst while the
    // other side waits. In that case the port falls through to round-robin.
    // last_q then points at the owner, so the waiting requester wins.
    hold0 = (state_q == StOwn0) && rq0_req && !(burst_full && rq1_req);
    hold1 = (state_q == StOwn1) && rq1_req && !(burst_full && rq0_req);
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    if (reset_reset) begin
      gnt0 = 1'b0;
    end else if (hold0) begin
      gnt0 = 1'b1;
    end else if (hold1) begin
      gnt1 = 1'b1;
    end else if (rq0_req && rq1_req) begin
      gnt0 = last_q;
      gnt1 = !last_q;
    end else begin
      gnt0 = rq0_req;
      gnt1 = rq1_req;
    end
    lock_sel = gnt1 ? rq1_lock : rq0_lock;
    own_st   = gnt1 ? StOwn1 : StOwn0;
  end

  assign rq0_gnt = gnt0;
  assign rq1_gnt = gnt1;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      burst_cnt_q <= '0;
    end else if (gnt0 || gnt1) begin
      last_q <= gnt1;
      if (lock_sel) begin
        state_q <= own_st;
        if (state_q != own_st) begin
          burst_cnt_q <= CntW'(1);
        end else if (!burst_full) begin
          burst_cnt_q <= burst_cnt_q + CntW'(1);
        end
      end else begin
        state_q     <= StIdle;
        burst_cnt_q <= '0;
      end
    end else begin
      state_q     <= StIdle;
      burst_cnt_q <= '0;
    end
  end

  // Command register; payload fields hold their value between transfers.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (gnt0 || gnt1) begin
      cs_q    <= 1'b1;
      we_q    <= gnt1 ? rq1_write : rq0_write;
      addr_q  <= gnt1 ? rq1_addr  : rq0_addr;
      wdata_q <= gnt1 ? rq1_wdata : rq0_wdata;
      be_q    <= gnt1 ? rq1_be    : rq0_be;
    end else begin
      cs_q <= 1'b0;
      we_q <= 1'b0;
    end
  end

  // Forcing the outputs low with reset makes the port quiet in the reset cycle itself.
  assign mem_clken      = !reset_reset;
  assign mem_chipselect = cs_q & !reset_reset;
  assign mem_write      = we_q & !reset_reset;
  assign mem_address    = addr_q & {ADDR_W{!reset_reset}};
  assign mem_writedata  = wdata_q & {DATA_W{!reset_reset}};
  assign mem_byteenable = be_q & {BeW{!reset_reset}};

  // Tag stage 0 matches the command cycle. Stage READ_LATENCY matches the data cycle.
  assign rd_xfer = (gnt0 && !rq0_write) || (gnt1 && !rq1_write);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      tag_v_q <= '0;
      tag_o_q <= '0;
    end else begin
      tag_v_q <= {tag_v_q[TagStages-2:0], rd_xfer};
      tag_o_q <= {tag_o_q[TagStages-2:0], gnt1};
    end
  end

  assign rq0_rvalid = tag_v_q[TagStages-1] && !tag_o_q[TagStages-1] && !reset_reset;
  assign rq1_rvalid = tag_v_q[TagStages-1] &&  tag_o_q[TagStages-1] && !reset_reset;
  assign rq0_rdata  = mem_readdata;
  assign rq1_rdata  = mem_readdata;

endmodule

// File: tb/tb_bg_mem_port_arbiter.sv
// Bench for bg_mem_port_arbiter. Three instances share the same requester stimulus.
// They use READ_LATENCY 1, 2 and 3, all with MAX_BURST 4. Directed checks use the
// latency-1 instance. A random phase scores read returns on all three instances.
module tb_bg_mem_port_arbiter;
  localparam int AW = 13;
  localparam int DW = 16;
  localparam int BW = 2;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          rq0_req, rq0_lock, rq0_write, rq1_req, rq1_lock, rq1_write;
  logic [AW-1:0] rq0_addr, rq1_addr;
  logic [DW-1:0] rq0_wdata, rq1_wdata;
  logic [BW-1:0] rq0_be, rq1_be;

  logic          gnt0[NI], gnt1[NI], rv0[NI], rv1[NI];
  logic [DW-1:0] rd0[NI], rd1[NI], m_wd[NI], m_rd[NI];
  logic [AW-1:0] m_addr[NI];
  logic          m_cs[NI], m_clken[NI], m_we[NI];
  logic [BW-1:0] m_be[NI];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit sb_en    = 1'b0;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {a[7:0], 3'b101, a[12:8]} ^ 16'h3C5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    bg_mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(g + 1), .MAX_BURST(4)
    ) u_dut (
      .clk_clk(clk), .reset_reset(rst),
      .rq0_req(rq0_req), .rq0_lock(rq0_lock), .rq0_write(rq0_write),
      .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata), .rq0_be(rq0_be),
      .rq0_gnt(gnt0[g]), .rq0_rvalid(rv0[g]), .rq0_rdata(rd0[g]),
      .rq1_req(rq1_req), .rq1_lock(rq1_lock), .rq1_write(rq1_write),
      .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata), .rq1_be(rq1_be),
      .rq1_gnt(gnt1[g]), .rq1_rvalid(rv1[g]), .rq1_rdata(rd1[g]),
      .mem_address(m_addr[g]), .mem_chipselect(m_cs[g]), .mem_clken(m_clken[g]),
      .mem_write(m_we[g]), .mem_writedata(m_wd[g]), .mem_byteenable(m_be[g]),
      .mem_readdata(m_rd[g])
    );

    // Memory model: data leaves the memory g+1 cycles after the command cycle.
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] pipe [g+1];
    logic [DW-1:0] w;
    bit init_done = 1'b0;
    always @(posedge clk) begin
      if (!init_done) begin
        for (int i = 0; i < 2**AW; i++) mem[i] = init_val(AW'(i));
        init_done = 1'b1;
      end
      pipe[0] <= mem[m_addr[g]];
      for (int k = 1; k <= g; k++) pipe[k] <= pipe[k-1];
      if (m_cs[g] && m_we[g]) begin
        w = mem[m_addr[g]];
        for (int b = 0; b < BW; b++) if (m_be[g][b]) w[8*b+:8] = m_wd[g][8*b+:8];
        mem[m_addr[g]] = w;
      end
    end
    assign m_rd[g] = pipe[g];

    // Read-return scoreboard, in slots indexed by the cycle number mod 8.
    logic          sv[8];
    logic          so[8];
    logic [AW-1:0] sa[8];
    int unsigned   idx, nidx;
    always @(negedge clk) begin
      if (!sb_en) begin
        for (int k = 0; k < 8; k++) sv[k] = 1'b0;
      end else begin
        idx = cyc % 8;
        check($sformatf("rv0_rl%0d", g + 1), 32'(rv0[g]), 32'(sv[idx] && !so[idx]));
        check($sformatf("rv1_rl%0d", g + 1), 32'(rv1[g]), 32'(sv[idx] && so[idx]));
        if (sv[idx])
          check($sformatf("rdata_rl%0d", g + 1), 32'(so[idx] ? rd1[g] : rd0[g]),
                32'(init_val(sa[idx])));
        sv[idx] = 1'b0;
        check($sformatf("gnt_excl_rl%0d", g + 1), 32'(gnt0[g] & gnt1[g]), 32'(0));
        check($sformatf("gnt_noreq_rl%0d", g + 1),
              32'((gnt0[g] & !rq0_req) | (gnt1[g] & !rq1_req)), 32'(0));
        nidx = (cyc + g + 2) % 8;
        if (gnt0[g] && !rq0_write) begin
          sv[nidx] = 1'b1; so[nidx] = 1'b0; sa[nidx] = rq0_addr;
        end
        if (gnt1[g] && !rq1_write) begin
          sv[nidx] = 1'b1; so[nidx] = 1'b1; sa[nidx] = rq1_addr;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic check_mem_zero(input string tag);
    check({tag, "_cs"}, 32'(m_cs[0]), 32'(0));
    check({tag, "_clken"}, 32'(m_clken[0]), 32'(0));
    check({tag, "_we"}, 32'(m_we[0]), 32'(0));
    check({tag, "_addr"}, 32'(m_addr[0]), 32'(0));
    check({tag, "_wd"}, 32'(m_wd[0]), 32'(0));
    check({tag, "_be"}, 32'(m_be[0]), 32'(0));
  endtask

  logic [DW-1:0] v;
  int n0, n1, j;
  bit g0s, g1s;

  initial begin
    rst = 1'b1;
    rq0_req = 1'b1; rq0_lock = 1'b0; rq0_write = 1'b0; rq0_addr = 13'h0040;
    rq0_wdata = '0; rq0_be = 2'b11;
    rq1_req = 1'b0; rq1_lock = 1'b0; rq1_write = 1'b0; rq1_addr = '0;
    rq1_wdata = '0; rq1_be = 2'b11;
    tick(); tick();
    smp();
    check("rst_gnt0", 32'(gnt0[0]), 32'(0));
    check("rst_rv0", 32'(rv0[0]), 32'(0));
    check_mem_zero("rst");
    tick();

    // Single read from rq0
    rst = 1'b0;
    smp();
    check("t1_gnt0", 32'(gnt0[0]), 32'(1));
    check("t1_gnt1", 32'(gnt1[0]), 32'(0));
    tick();
    rq0_req = 1'b0;
    smp();
    check("t1_cs", 32'(m_cs[0]), 32'(1));
    check("t1_addr", 32'(m_addr[0]), 32'h40);
    check("t1_we", 32'(m_we[0]), 32'(0));
    check("t1_clken", 32'(m_clken[0]), 32'(1));
    check("t1_rv0_early", 32'(rv0[0]), 32'(0));
    tick();
    smp();
    check("t1_rv0", 32'(rv0[0]), 32'(1));
    check("t1_rd0", 32'(rd0[0]), 32'(init_val(13'h0040)));
    check("t1_rv1", 32'(rv1[0]), 32'(0));
    check("t1_cs_idle", 32'(m_cs[0]), 32'(0));
    tick();

    // Alternating streams; last grant went to rq0, so rq1 leads
    n0 = 0; n1 = 0;
    for (int k = 0; k < 10; k++) begin
      rq0_req = (k < 8); rq1_req = (k < 8);
      rq0_addr = AW'(32'h100 + n0); rq1_addr = AW'(32'h200 + n1);
      smp();
      if (k < 8) begin
        check("t2_gnt0", 32'(gnt0[0]), 32'(k % 2 == 1));
        check("t2_gnt1", 32'(gnt1[0]), 32'(k % 2 == 0));
      end
      if (k >= 2) begin
        j = k - 2;
        check("t2_rv0", 32'(rv0[0]), 32'(j % 2 == 1));
        check("t2_rv1", 32'(rv1[0]), 32'(j % 2 == 0));
        if (j % 2 == 0) check("t2_rd1", 32'(rd1[0]), 32'(init_val(AW'(32'h200 + j / 2))));
        else            check("t2_rd0", 32'(rd0[0]), 32'(init_val(AW'(32'h100 + j / 2))));
      end
      if (gnt0[0]) n0++;
      if (gnt1[0]) n1++;
      tick();
    end

    // Burst lock: rq1 holds four grants, then rq0 is forced in
    rq0_req = 1'b1; rq0_addr = 13'h0300;
    rq1_req = 1'b1; rq1_lock = 1'b1; rq1_addr = 13'h0301;
    for (int k = 0; k < 6; k++) begin
      smp();
      check("t3_gnt1", 32'(gnt1[0]), 32'(k != 4));
      check("t3_gnt0", 32'(gnt0[0]), 32'(k == 4));
      if (gnt0[0]) rq0_req = 1'b0;
      tick();
    end
    rq1_req = 1'b0; rq1_lock = 1'b0;
    tick(); tick(); tick();

    // Upper-byte write, then read back
    rq0_req = 1'b1; rq0_write = 1'b1; rq0_addr = 13'h1FFF; rq0_wdata = 16'hBEEF;
    rq0_be = 2'b10;
    smp();
    check("t4_gnt_wr", 32'(gnt0[0]), 32'(1));
    tick();
    rq0_write = 1'b0; rq0_be = 2'b11;
    smp();
    check("t4_cs", 32'(m_cs[0]), 32'(1));
    check("t4_we", 32'(m_we[0]), 32'(1));
    check("t4_be", 32'(m_be[0]), 32'h2);
    check("t4_wd", 32'(m_wd[0]), 32'hBEEF);
    check("t4_addr", 32'(m_addr[0]), 32'h1FFF);
    check("t4_gnt_rd", 32'(gnt0[0]), 32'(1));
    tick();
    rq0_req = 1'b0;
    smp();
    check("t4_rd_cmd_we", 32'(m_we[0]), 32'(0));
    check("t4_no_rv_write", 32'(rv0[0]), 32'(0));
    tick();
    smp();
    v = init_val(13'h1FFF);
    check("t4_rv0", 32'(rv0[0]), 32'(1));
    check("t4_rd0", 32'(rd0[0]), 32'({8'hBE, v[7:0]}));
    tick();

    // Reset with two reads in flight
    rq0_req = 1'b1; rq0_addr = 13'h0010;
    smp();
    check("t5_gnt0", 32'(gnt0[0]), 32'(1));
    tick();
    rq0_req = 1'b0; rq1_req = 1'b1; rq1_addr = 13'h0011;
    smp();
    check("t5_gnt1", 32'(gnt1[0]), 32'(1));
    tick();
    rst = 1'b1; rq0_req = 1'b1; rq0_addr = 13'h0012; rq1_addr = 13'h0013;
    smp();
    check_mem_zero("t5_rst");
    check("t5_rst_gnt0", 32'(gnt0[0]), 32'(0));
    check("t5_rst_gnt1", 32'(gnt1[0]), 32'(0));
    check("t5_rst_rv0", 32'(rv0[0]), 32'(0));
    check("t5_rst_rv1", 32'(rv1[0]), 32'(0));
    tick();
    rst = 1'b0;
    smp();
    check("t5_post_gnt0", 32'(gnt0[0]), 32'(1));
    check("t5_post_gnt1", 32'(gnt1[0]), 32'(0));
    check("t5_post_rv0", 32'(rv0[0]), 32'(0));
    check("t5_post_rv1", 32'(rv1[0]), 32'(0));
    tick();
    rq0_req = 1'b0;
    smp();
    check("t5_next_gnt1", 32'(gnt1[0]), 32'(1));
    check("t5_next_rv0", 32'(rv0[0]), 32'(0));
    check("t5_next_rv1", 32'(rv1[0]), 32'(0));
    tick();
    rq1_req = 1'b0;
    repeat (5) tick();

    // Random traffic across all latencies; writes use be=0 so memory stays at init_val
    sb_en = 1'b1;
    g0s = 1'b1; g1s = 1'b1;
    rq0_be = 2'b00; rq1_be = 2'b00;
    for (int c = 0; c < 300; c++) begin
      if (!rq0_req || g0s) begin
        rq0_req   = ($urandom_range(0, 3) != 0);
        rq0_lock  = ($urandom_range(0, 3) == 0);
        rq0_write = ($urandom_range(0, 4) == 0);
        rq0_addr  = AW'($urandom_range(0, 255));
      end
      if (!rq1_req || g1s) begin
        rq1_req   = ($urandom_range(0, 3) != 0);
        rq1_lock  = ($urandom_range(0, 3) == 0);
        rq1_write = ($urandom_range(0, 4) == 0);
        rq1_addr  = AW'($urandom_range(0, 255));
      end
      smp();
      g0s = gnt0[0];
      g1s = gnt1[0];
      tick();
    end
    rq0_req = 1'b0; rq1_req = 1'b0; rq0_lock = 1'b0; rq1_lock = 1'b0;
    repeat (6) tick();
    sb_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
